mem_bist: RTL

MEM_BIST -- requirements
Module: mem_bist

---
 rtl/mem_bist_pkg.sv | 17 +
 rtl/mem_bist_pattern.sv | 44 ++++
 rtl/mem_bist.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/mem_bist_pkg.sv
// Shared state encoding and pattern-mode constants for the memory BIST.
package mem_bist_pkg;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_WRITE = 3'd1,
    S_READ  = 3'd2,
    S_DRAIN = 3'd3,
    S_DONE  = 3'd4
  } state_e;

  localparam logic [1:0] MODE_ADDR  = 2'd0;
  localparam logic [1:0] MODE_WALK  = 2'd1;
  localparam logic [1:0] MODE_CHECK = 2'd2;
  localparam logic [1:0] MODE_NADDR = 2'd3;

endpackage

// File: rtl/mem_bist_pattern.sv
// Combinational test-pattern generator: maps (address, mode) to a data word.
module mem_bist_pattern
  import mem_bist_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned ADDR_WIDTH = 8
) (
  input  logic [ADDR_WIDTH-1:0] addr_i,
  input  logic [1:0]            mode_i,
  output logic [DATA_WIDTH-1:0] data_o
);

  logic [DATA_WIDTH+ADDR_WIDTH-1:0] addr_ext;
  logic [DATA_WIDTH-1:0]            addr_pat;
  logic [DATA_WIDTH-1:0]            walk_pat;
  logic [DATA_WIDTH-1:0]            check_pat;
  logic [31:0]                      walk_idx;

  // Zero-extend or truncate the address to the data width in one step.
  assign addr_ext = {{DATA_WIDTH{1'b0}}, addr_i};
  assign addr_pat = addr_ext[DATA_WIDTH-1:0];
  assign walk_idx = 32'(addr_i) % 32'(DATA_WIDTH);

  always_comb begin
    walk_pat  = '0;
    check_pat = '0;
    for (int i = 0; i < int'(DATA_WIDTH); i++) begin
      walk_pat[i]  = (walk_idx == 32'(i));
      check_pat[i] = ((i % 2) == 0) ? ~addr_i[0] : addr_i[0];
    end
  end

  always_comb begin
    data_o = addr_pat;
    case (mode_i)
      MODE_ADDR:  data_o = addr_pat;
      MODE_WALK:  data_o = walk_pat;
      MODE_CHECK: data_o = check_pat;
      MODE_NADDR: data_o = ~addr_pat;
      default:    data_o = addr_pat;
    endcase
  end

endmodule

// File: rtl/mem_bist.sv
// Memory BIST: writes a full pattern pass, reads it back, counts mismatches
// with a one-cycle pipelined compare, and reports pass/fail plus a heartbeat.
module mem_bist
  import mem_bist_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned ADDR_WIDTH = 8,
  parameter int unsigned ERR_WIDTH  = 8,
  parameter logic [24:0] ACT_DIV    = 25'd4194304
) (
  input  logic                  clk_i,
  input  logic                  reset_ni,
  input  logic                  start_i,
  input  logic [1:0]            mode_i,
  input  logic [DATA_WIDTH-1:0] mem_data_i,
  output logic [ADDR_WIDTH-1:0] mem_addr_o,
  output logic [DATA_WIDTH-1:0] mem_data_o,
  output logic                  mem_we_no,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  pass_o,
  output logic [ERR_WIDTH-1:0]  err_count_o,
  output logic [ADDR_WIDTH-1:0] fail_addr_o,
  output logic                  activity_o
);

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = '1;
  localparam logic [ERR_WIDTH-1:0]  ERR_MAX   = '1;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [ADDR_WIDTH-1:0] cmp_addr_q, cmp_addr_d;
  logic [ADDR_WIDTH-1:0] fail_q, fail_d;
  logic [1:0]            mode_q, mode_d;
  logic [DATA_WIDTH-1:0] wdata_q, wr_pat, cmp_pat;
  logic                  we_n_q, we_n_d;
  logic                  busy_q, done_q;
  logic                  pass_q, pass_d;
  logic                  cmp_valid_q, cmp_valid_d;
  logic [ERR_WIDTH-1:0]  err_q, err_d;
  logic [24:0]           act_cnt_q;
  logic                  act_q;
  logic                  mismatch;

  // Write path looks at the next address so the registered data lines up.
  mem_bist_pattern #(.DATA_WIDTH(DATA_WIDTH), .ADDR_WIDTH(ADDR_WIDTH)) u_wr_pat (
    .addr_i (addr_d),
    .mode_i (mode_d),
    .data_o (wr_pat)
  );

  mem_bist_pattern #(.DATA_WIDTH(DATA_WIDTH), .ADDR_WIDTH(ADDR_WIDTH)) u_cmp_pat (
    .addr_i (cmp_addr_q),
    .mode_i (mode_q),
    .data_o (cmp_pat)
  );

  assign mismatch = cmp_valid_q && (mem_data_i != cmp_pat);

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    mode_d      = mode_q;
    we_n_d      = 1'b1;
    pass_d      = pass_q;
    err_d       = err_q;
    fail_d      = fail_q;
    cmp_valid_d = (state_q == S_READ);
    cmp_addr_d  = addr_q;
    if (mismatch) begin
      if (err_q != ERR_MAX) err_d = err_q + 1'b1;
      if (err_q == '0)      fail_d = cmp_addr_q;
    end
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start_i) begin
          state_d = S_WRITE;
          addr_d  = '0;
          mode_d  = mode_i;
          we_n_d  = 1'b0;
          pass_d  = 1'b0;
          err_d   = '0;
          fail_d  = '0;
        end
      end
      S_WRITE: begin
        if (addr_q == LAST_ADDR) begin
          state_d = S_READ;
          addr_d  = '0;
        end else begin
          addr_d = addr_q + 1'b1;
          we_n_d = 1'b0;
        end
      end
      S_READ: begin
        if (addr_q == LAST_ADDR) state_d = S_DRAIN;
        else                     addr_d  = addr_q + 1'b1;
      end
      S_DRAIN: begin
        state_d = S_DONE;
        pass_d  = (err_d == '0);
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q     <= S_IDLE;
      addr_q      <= '0;
      cmp_addr_q  <= '0;
      fail_q      <= '0;
      mode_q      <= MODE_ADDR;
      wdata_q     <= '0;
      we_n_q      <= 1'b1;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      pass_q      <= 1'b0;
      cmp_valid_q <= 1'b0;
      err_q       <= '0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      cmp_addr_q  <= cmp_addr_d;
      fail_q      <= fail_d;
      mode_q      <= mode_d;
      wdata_q     <= wr_pat;
      we_n_q      <= we_n_d;
      busy_q      <= (state_d == S_WRITE) || (state_d == S_READ) || (state_d == S_DRAIN);
      done_q      <= (state_d == S_DONE);
      pass_q      <= pass_d;
      cmp_valid_q <= cmp_valid_d;
      err_q       <= err_d;
    end
  end

  // Free-running heartbeat, independent of the test FSM.
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      act_cnt_q <= '0;
      act_q     <= 1'b0;
    end else if (act_cnt_q == ACT_DIV - 25'd1) begin
      act_cnt_q <= '0;
      act_q     <= ~act_q;
    end else begin
      act_cnt_q <= act_cnt_q + 25'd1;
    end
  end

  assign mem_addr_o  = addr_q;
  assign mem_data_o  = wdata_q;
  assign mem_we_no   = we_n_q;
  assign busy_o      = busy_q;
  assign done_o      = done_q;
  assign pass_o      = pass_q;
  assign err_count_o = err_q;
  assign fail_addr_o = fail_q;
  assign activity_o  = act_q;

endmodule
